// File: rtl/mul_fixpoint_float_pkg.sv
// Shared signed fixed-point definitions: default Q8.8 geometry and the
// saturation limits used by the multiplier and other arithmetic blocks.
package mul_fixpoint_float_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int FRAC_DEF  = 8;

  localparam logic [WIDTH_DEF-1:0] SAT_MAX = 16'h7FFF;
  localparam logic [WIDTH_DEF-1:0] SAT_MIN = 16'h8000;

endpackage

// File: rtl/mul_fixpoint_float_sat_shift.sv
// Combinational arithmetic right shift with signed saturation to OUT_W bits.
// Reusable by any fixed-point datapath that needs to narrow a wide result.
module fix_sat_shift
  import mul_fixpoint_float_pkg::*;
#(
  parameter int IN_W  = 2 * WIDTH_DEF,
  parameter int OUT_W = WIDTH_DEF,
  parameter int SHIFT = FRAC_DEF
) (
  input  logic [IN_W-1:0]  din,
  output logic [OUT_W-1:0] dout,
  output logic             ovf
);

  localparam logic [OUT_W-1:0] MAX_VAL =
    (OUT_W == WIDTH_DEF) ? OUT_W'(SAT_MAX) : {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] MIN_VAL =
    (OUT_W == WIDTH_DEF) ? OUT_W'(SAT_MIN) : {1'b1, {(OUT_W-1){1'b0}}};

  logic [IN_W-1:0]     shifted;
  logic [IN_W-OUT_W:0] upper;

  // The value fits when every bit from the result sign bit upward agrees.
  always_comb begin
    shifted = $signed(din) >>> SHIFT;
    upper   = shifted[IN_W-1:OUT_W-1];
    dout    = shifted[OUT_W-1:0];
    ovf     = 1'b0;
    if (!((&upper) || !(|upper))) begin
      ovf  = 1'b1;
      dout = shifted[IN_W-1] ? MIN_VAL : MAX_VAL;
    end
  end

endmodule

// File: rtl/mul_fixpoint_float.sv
// Three-stage pipelined signed fixed-point multiplier with truncation toward
// negative infinity and saturation; one operand pair accepted per cycle.
module mul_fixpoint_float
  import mul_fixpoint_float_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int FRAC  = FRAC_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  output logic [WIDTH-1:0] mul_out,
  output logic             ovf
);

  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               v1;
  logic [2*WIDTH-1:0] prod_d;
  logic [2*WIDTH-1:0] prod_q;
  logic               v2;
  logic [WIDTH-1:0]   sat_out;
  logic               sat_ovf;

  // Sign-extending both operands makes the low 2*WIDTH bits of the product exact.
  assign prod_d = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};

  fix_sat_shift #(
    .IN_W  (2 * WIDTH),
    .OUT_W (WIDTH),
    .SHIFT (FRAC)
  ) u_sat (
    .din  (prod_q),
    .dout (sat_out),
    .ovf  (sat_ovf)
  );

  // Result registers only load on a valid slot, so bubbles keep the last answer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      v1        <= 1'b0;
      prod_q    <= '0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      mul_out   <= '0;
      ovf       <= 1'b0;
    end else begin
      a_q       <= A;
      b_q       <= B;
      v1        <= in_valid;
      prod_q    <= prod_d;
      v2        <= v1;
      out_valid <= v2;
      if (v2) begin
        mul_out <= sat_out;
        ovf     <= sat_ovf;
      end
    end
  end

endmodule

// File: tb/tb_mul_fixpoint_float.sv
// Directed, table-driven bench for the pipelined Q8.8 multiplier: latency,
// signed/saturating results, streaming with gaps, and mid-flight reset.
module tb_mul_fixpoint_float;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_out;
    logic        exp_ovf;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] A;
  logic [15:0] B;
  logic        out_valid;
  logic [15:0] mul_out;
  logic        ovf;

  int          checks;
  int          errors;
  logic [15:0] last_out;
  logic        last_ovf;
  vec_t        vecs[14];

  mul_fixpoint_float #(.WIDTH(16), .FRAC(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .mul_out   (mul_out),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic v, input logic [15:0] a, input logic [15:0] b);
    in_valid = v;
    A        = a;
    B        = b;
  endtask

  task automatic checkOutput(input string name, input logic exp_v,
                             input logic [15:0] exp_out, input logic exp_ovf);
    checks++;
    if (out_valid !== exp_v || mul_out !== exp_out || ovf !== exp_ovf) begin
      errors++;
      $display("[TB] FAIL %s: got valid=%0b out=%h ovf=%0b, required valid=%0b out=%h ovf=%0b",
               name, out_valid, mul_out, ovf, exp_v, exp_out, exp_ovf);
    end
  endtask

  // One isolated operation: exact 3-edge latency, then hold during the bubble.
  task automatic runOne(input string name, input int idx);
    @(negedge clk);
    applyStimulus(1'b1, vecs[idx].a, vecs[idx].b);
    @(negedge clk);
    applyStimulus(1'b0, 16'($urandom), 16'($urandom));
    checkOutput({name, "_lat1"}, 1'b0, last_out, last_ovf);
    @(negedge clk);
    applyStimulus(1'b0, 16'($urandom), 16'($urandom));
    checkOutput({name, "_lat2"}, 1'b0, last_out, last_ovf);
    @(negedge clk);
    checkOutput({name, "_result"}, 1'b1, vecs[idx].exp_out, vecs[idx].exp_ovf);
    last_out = vecs[idx].exp_out;
    last_ovf = vecs[idx].exp_ovf;
    @(negedge clk);
    checkOutput({name, "_hold"}, 1'b0, last_out, last_ovf);
  endtask

  initial begin
    bit slot_valid[13];
    int slot_idx[13];

    checks   = 0;
    errors   = 0;
    last_out = 16'h0000;
    last_ovf = 1'b0;

    vecs[0]  = '{16'h0100, 16'h0100, 16'h0100, 1'b0};
    vecs[1]  = '{16'h0100, 16'h0200, 16'h0200, 1'b0};
    vecs[2]  = '{16'h0200, 16'h0100, 16'h0200, 1'b0};
    vecs[3]  = '{16'h0100, 16'h0080, 16'h0080, 1'b0};
    vecs[4]  = '{16'h0300, 16'h0300, 16'h0900, 1'b0};
    vecs[5]  = '{16'h0030, 16'h0030, 16'h0009, 1'b0};
    vecs[6]  = '{16'h00a0, 16'h0040, 16'h0028, 1'b0};
    vecs[7]  = '{16'h0300, 16'hFE00, 16'hFA00, 1'b0};
    vecs[8]  = '{16'h0000, 16'hFA00, 16'h0000, 1'b0};
    vecs[9]  = '{16'h0100, 16'hFF00, 16'hFF00, 1'b0};
    vecs[10] = '{16'h7F00, 16'h0200, 16'h7FFF, 1'b1};
    vecs[11] = '{16'h8000, 16'h0200, 16'h8000, 1'b1};
    vecs[12] = '{16'h0001, 16'hFFFF, 16'hFFFF, 1'b0};
    vecs[13] = '{16'hFA00, 16'h0000, 16'h0000, 1'b0};

    // Reset state, with live-looking inputs present during reset.
    rst_n = 1'b0;
    applyStimulus(1'b1, 16'h0300, 16'h0300);
    #1;
    checkOutput("reset_state", 1'b0, 16'h0000, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("reset_hold", 1'b0, 16'h0000, 1'b0);
    applyStimulus(1'b0, 16'h0000, 16'h0000);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      runOne($sformatf("vec%0d", i), i);
    end

    // Streaming: 8 back-to-back, a 2-cycle gap, then 3 more including saturation.
    for (int s = 0; s < 13; s++) begin
      slot_valid[s] = (s < 8) || (s >= 10);
      slot_idx[s]   = (s < 8) ? s : s;
    end
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (c >= 3) begin
        if (slot_valid[c-3]) begin
          last_out = vecs[slot_idx[c-3]].exp_out;
          last_ovf = vecs[slot_idx[c-3]].exp_ovf;
          checkOutput($sformatf("stream_slot%0d", c - 3), 1'b1, last_out, last_ovf);
        end else begin
          checkOutput($sformatf("stream_gap%0d", c - 3), 1'b0, last_out, last_ovf);
        end
      end
      if (c < 13) begin
        applyStimulus(slot_valid[c], vecs[slot_idx[c]].a, vecs[slot_idx[c]].b);
      end else begin
        applyStimulus(1'b0, 16'h0000, 16'h0000);
      end
    end

    // Mid-flight reset: two operations in the pipe, reset pulse flushes them.
    @(negedge clk);
    applyStimulus(1'b1, vecs[4].a, vecs[4].b);
    @(negedge clk);
    applyStimulus(1'b1, vecs[10].a, vecs[10].b);
    @(negedge clk);
    applyStimulus(1'b0, 16'h0000, 16'h0000);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_immediate", 1'b0, 16'h0000, 1'b0);
    last_out = 16'h0000;
    last_ovf = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput($sformatf("rst_flushed%0d", c), 1'b0, 16'h0000, 1'b0);
    end

    runOne("post_reset", 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_fixpoint_float.md
MUL_FIXPOINT_FLOAT -- requirements
Module: mul_fixpoint_float

Interface
REQ-001 Parameter WIDTH, default 16: operand and result width in bits, signed two's complement.
REQ-002 Parameter FRAC, default 8: fractional bits, giving Q8.8 format where 16'h0100 = 1.0.
REQ-003 clk  input  1: single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1: reset, asynchronous and active-low.
REQ-005 in_valid  input  1: A and B are valid this cycle.
REQ-006 A  input  WIDTH: multiplicand, signed Q8.8.
REQ-007 B  input  WIDTH: multiplier, signed Q8.8.
REQ-008 out_valid  output  1: mul_out and ovf are valid this cycle.
REQ-009 mul_out  output  WIDTH: product, signed Q8.8.
REQ-010 ovf  output  1: product saturated.

Function
REQ-011 The block SHALL compute the full signed product P = A*B at 2*WIDTH bits, then arithmetic-shift it right by FRAC.
- Truncation is toward negative infinity; there is no rounding.
REQ-012 If the shifted value exceeds the signed WIDTH-bit range, the result SHALL saturate and ovf SHALL be 1 for that result; otherwise ovf = 0.
- Above range: 16'h7FFF.
- Below range: 16'h8000.
REQ-013 The block SHALL be a 3-stage pipeline, with out_valid asserted exactly 3 cycles after in_valid was sampled high.
- Stage 1: register operands.
- Stage 2: register the 32-bit product.
- Stage 3: register the shifted, saturated result and ovf.
REQ-014 The block SHALL accept a new operand pair every cycle; there is no backpressure and no stall.
REQ-015 A cycle with in_valid = 0 SHALL propagate a bubble: out_valid = 0 three cycles later.
REQ-016 When out_valid = 0, mul_out and ovf SHALL hold their last valid values.
REQ-017 Operand values SHALL be fully decoupled from the inputs after stage 1; A and B may change every cycle.
REQ-018 Zero times any value, including negative values, SHALL give 16'h0000 with ovf = 0.

Reset
REQ-019 Asserting rst_n low SHALL immediately clear all pipeline registers, mul_out, ovf and out_valid to 0.
REQ-020 Reset asserted mid-operation SHALL discard all in-flight operations, with no out_valid for them after reset is released.
REQ-021 The first in_valid sampled after reset release SHALL produce out_valid 3 cycles later.

Structure
REQ-022 WIDTH and FRAC defaults and the saturation constants (MAX = 16'h7FFF, MIN = 16'h8000) SHALL live in a shared fixed-point package.
REQ-023 The shift/saturate logic SHALL be one combinational sub-module, fix_sat_shift, reusable by adders and MAC blocks.

Verification
REQ-024 The bench SHALL cover these directed scenarios; all values in Q8.8.
- 0100*0100 -> 0100; 0100*0200 -> 0200; 0200*0100 -> 0200; 0100*0080 -> 0080. All with ovf = 0, 3 cycles after input.
- 0300*0300 -> 0900; 0030*0030 -> 0009; 00a0*0040 -> 0028. Each exact, ovf = 0.
- 0300*FE00 -> FA00; 0000*FA00 -> 0000; 0100*FF00 -> FF00. Signed handling.
- 7F00*0200 -> 7FFF with ovf = 1; 8000*0200 -> 8000 with ovf = 1; 0001*FFFF -> FFFF, which checks truncation toward -inf.
- Back-to-back inputs on 8 consecutive cycles -> 8 consecutive out_valid pulses with results in order. An in_valid gap of 2 cycles -> a matching 2-cycle out_valid gap.
- rst_n low for one cycle while 2 operations are in flight -> immediate zero outputs and no out_valid for the flushed operations.
